// File: rtl/tt_prog_counter_pkg.sv
// Shared constants and helpers for the programmable counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_prog_counter_pkg;

    // Widest counter the block supports; term_val returns this many bits.
    localparam int MAX_W = 16;

    // End-of-range behaviour select; 2'b11 is reserved and treated as wrap.
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    // Terminal value for the current direction, zero-extended to MAX_W bits:
    // all ones of the given width when counting up, zero when counting down.
    function automatic logic [MAX_W-1:0] term_val(input logic dir, input int width);
        logic [MAX_W-1:0] ones;
        ones = '1;
        return dir ? '0 : (ones >> (MAX_W - width));
    endfunction

endpackage

// File: rtl/tt_prog_counter_if.sv
// Control/status bundle between pin decode and the programmable counter.
// Latency: n/a (wires only).
// Backpressure: none; controls are sampled every clk, status is always valid.
//
// master drives en/dir/mode/load/load_val/presc_div/cmp_val and observes
// count/tc/match/done; slave (the counter) is the reverse.
interface tt_prog_counter_if #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
);
    import tt_prog_counter_pkg::*;

    logic               en;
    logic               dir;
    logic [1:0]         mode;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [PRESC_W-1:0] presc_div;
    logic [WIDTH-1:0]   cmp_val;
    logic [WIDTH-1:0]   count;
    logic               tc;
    logic               match;
    logic               done;

    modport master (
        output en, dir, mode, load, load_val, presc_div, cmp_val,
        input  count, tc, match, done
    );

    modport slave (
        input  en, dir, mode, load, load_val, presc_div, cmp_val,
        output count, tc, match, done
    );

endinterface

// File: rtl/tt_tick_gen.sv
// Prescaler: emits one tick every div+1 enabled cycles.
// Latency: tick is combinational from the registered prescaler (same cycle).
// Backpressure: en=0 freezes the prescaler in place; clr forces it to 0.
//
// Ports: clk, rst_n (sync, active-low), en (advance), clr (restart phase),
//        div (period-1), tick (step strobe).
module tt_tick_gen #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);
    import tt_prog_counter_pkg::*;

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    // Equality compare only: if div drops below the current phase, the
    // prescaler rolls through its maximum rather than ticking early.
    always_comb begin
        tick    = en && (presc_q == div);
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/tt_prog_counter.sv
// Programmable up/down counter with prescaler, load, wrap/saturate/one-shot.
// Latency: count updates on the tick edge; tc/match are registered alongside it.
// Backpressure: en=0 holds all state; load and reset act regardless of en.
//
// Ports: clk, rst_n (sync, active-low), bus (slave side of tt_prog_counter_if:
//        en, dir, mode, load, load_val, presc_div, cmp_val in;
//        count, tc, match, done out).
module tt_prog_counter #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    tt_prog_counter_if.slave bus
);
    import tt_prog_counter_pkg::*;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             match_q, match_d;
    logic             done_q, done_d;

    logic             tick;
    logic             at_t;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] wrap_val;

    // A finished one-shot stops the prescaler so no further ticks (and no
    // repeated tc) are produced until a load restarts it.
    tt_tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en && !done_q),
        .clr   (bus.load),
        .div   (bus.presc_div),
        .tick  (tick)
    );

    assign at_t     = (MAX_W'(count_q) == term_val(bus.dir, WIDTH));
    assign step_val = bus.dir ? (count_q - 1'b1) : (count_q + 1'b1);
    // Wrap lands on the opposite end of the range: ~T.
    assign wrap_val = bus.dir ? '1 : '0;

    always_comb begin
        count_d = count_q;
        done_d  = done_q;
        tc_d    = 1'b0;
        match_d = 1'b0;
        if (bus.load) begin
            count_d = bus.load_val;
            done_d  = 1'b0;
            match_d = (bus.load_val == bus.cmp_val);
        end else if (tick) begin
            if (!at_t) begin
                count_d = step_val;
                match_d = (step_val == bus.cmp_val);
            end else begin
                tc_d = 1'b1;
                case (bus.mode)
                    MODE_SAT: begin
                        count_d = count_q;
                    end
                    MODE_ONESHOT: begin
                        count_d = count_q;
                        done_d  = 1'b1;
                    end
                    default: begin
                        count_d = wrap_val;
                        match_d = (wrap_val == bus.cmp_val);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            match_q <= match_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.match = match_q;
    assign bus.done  = done_q;

endmodule

// File: doc/tt_prog_counter.md
Name: tt_prog_counter

Overview:
Parametrised programmable counter for TinyTapeout user designs. It replaces the fixed 8-bit free-running start/stop counter with selectable width, up/down direction, a clock prescaler, parallel load, three end-of-range modes (wrap, saturate, one-shot), and registered terminal-count and compare-match pulses. It sits between the ui_in/uio_in pin decode and the uo_out/uio_out drivers.

Parameters:
WIDTH, 8, counter width in bits (2..16)
PRESC_W, 4, prescaler divide-field width in bits (1..8)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
en  in  1  run enable; 1 = count, 0 = hold (replaces old stop bit)
dir  in  1  0 = up, 1 = down
mode  in  2  end-of-range mode: 00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
load  in  1  parallel load strobe
load_val  in  WIDTH  value loaded into count
presc_div  in  PRESC_W  step period = presc_div+1 enabled clk cycles
cmp_val  in  WIDTH  compare value
count  out  WIDTH  registered counter value
tc  out  1  one-cycle terminal-count pulse
match  out  1  one-cycle compare-match pulse
done  out  1  one-shot finished flag (level)

Behaviour:
- Reset is decided as: rst_n synchronous active-low; clock clk. All state updates on posedge clk only.
- Reset values: count=0, tc=0, match=0, done=0, prescaler=0.
- Priority per cycle: reset > load > step > hold.
- Prescaler: internal PRESC_W-bit counter advances only while en=1 and done=0. A tick is produced in a cycle where prescaler==presc_div; that cycle the prescaler returns to 0. presc_div=0 gives a tick every enabled cycle. en=0 freezes the prescaler without clearing it. load clears it to 0. A presc_div change takes effect on the next compare; if prescaler > new presc_div, the prescaler wraps naturally through 2^PRESC_W-1 and no early tick occurs.
- Terminal value T: up = 2^WIDTH-1, down = 0.
- Step (tick and no load): if count != T, count = count±1. If count == T:
  - wrap: count = ~T (0 when counting up, max when counting down).
  - saturate: count holds at T.
  - one-shot: count holds at T and done is set to 1.
- tc: registered, high the cycle after any tick that occurs with count == T, in every mode. In saturate mode it repeats on each such tick. In one-shot mode it pulses once, because done blocks further ticks.
- match: registered, high the cycle after count takes a new value equal to cmp_val, whether by step or by load. No pulse while count holds. Wrap mode with cmp_val == T: match fires on arrival at T, not on the wrap.
- load: count = load_val, prescaler = 0, done = 0, and no tc. Takes effect whether en is 0 or 1.
- Latency: count changes on the clock edge that samples the tick. tc and match assert on the following cycle, one clock wide.
- dir change mid-count: applies from the next tick. T is evaluated with the current dir.
- rst_n low mid-operation: all state returns to reset values on the next edge, overriding load and any tick.
- Arithmetic is unsigned modulo 2^WIDTH. There are no X-propagating paths, and every always block is fully assigned.

Decomposition:
- Package tt_prog_counter_pkg holds:
  - mode localparams MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10;
  - a function term_val(dir, WIDTH).
- Sub-module tt_tick_gen (the prescaler):
  - inputs clk, rst_n, en, clr, div;
  - output tick.
- The top holds the count register, mode logic, tc/match/done registers, and the pin wrapper mapping onto tt_um ui_in/uo_out.

Test Plan:
1. Reset, WIDTH=8, presc_div=0, dir=0, mode=wrap, en=1: count 0,1,2,... each cycle; after 255 the count reads 0, and tc is high exactly one cycle, the cycle after the wrap edge.
2. presc_div=3, up, from 0: count increments every 4th cycle, reaching 5 at cycle 20. Dropping en for 7 cycles mid-period resumes with the same phase.
3. Down count, saturate, load_val=2: sequence 2,1,0,0,0. tc pulses on each tick while count is at 0, with no underflow to 255.
4. One-shot, up, load_val=253: sequence 253,254,255. Then done=1 with a single tc pulse and count frozen at 255 for 50 cycles. load_val=10 clears done and counting resumes at 11.
5. cmp_val=7, load_val=5, up: match is high exactly one cycle after count becomes 7. Loading 7 directly also pulses match once. While en=0 with count=7, match stays low.
6. Simultaneous load and tick at count=255 in wrap mode: count=load_val and tc=0. Asserting rst_n=0 in the same cycle as load gives count=0 and done=0 on the next edge.
